// File: rtl/led_mode_sequencer_pkg.sv
// ============================================================================
// Module      : led_mode_sequencer_pkg
// Description : Mode encodings and helpers shared by the LED mode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_mode_sequencer_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_INVERT = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // One-cycle commands decoded from the debounced buttons.
    typedef struct packed {
        logic home;
        logic next;
    } btn_cmd_t;

    // NEXT ordering wraps BLINK back to NORMAL through 2-bit overflow.
    function automatic logic [1:0] mode_after_next(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_mode_sequencer_button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : 2-flop synchronizer, stability-count debouncer and rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= level;
            // Release edges are deliberately ignored; only presses are commands.
            rise      <= level & ~r_level_d;
            if (r_sync2 != level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_mode_sequencer.sv
// ============================================================================
// Module      : led_mode_sequencer
// Description : Button-driven 4-mode LED sequencer (NORMAL/INVERT/CHASE/BLINK).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_mode_sequencer
    import led_mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8,
    parameter int LED_W           = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       switches,
    input  logic [1:0]       buttons,
    output logic [LED_W-1:0] leds,
    output logic [1:0]       mode
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [1:0]       w_level;
    logic [1:0]       w_rise;
    btn_cmd_t         w_cmd;
    logic [1:0]       w_mode_next;
    logic [LED_W-1:0] w_pat;
    logic [LED_W-1:0] w_led_next;

    logic [SW-1:0]    r_step_cnt;
    logic [LED_W-1:0] r_chase;
    logic             r_phase;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn_raw(buttons[i]),
                .level  (w_level[i]),
                .rise   (w_rise[i])
            );
        end
    endgenerate

    // A rise is only acted on while its button is still debounced high.
    assign w_cmd.next  = w_rise[0] & w_level[0];
    assign w_cmd.home  = w_rise[1] & w_level[1];
    assign w_mode_next = w_cmd.home ? MODE_NORMAL : mode_after_next(mode);
    assign w_pat       = LED_W'({switches, switches});

    always_comb begin
        w_led_next = w_pat;
        case (mode)
            MODE_NORMAL: w_led_next = w_pat;
            MODE_INVERT: w_led_next = ~w_pat;
            MODE_CHASE:  w_led_next = r_chase;
            MODE_BLINK:  w_led_next = r_phase ? w_pat : '0;
            default:     w_led_next = w_pat;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= MODE_NORMAL;
            leds       <= '0;
            r_step_cnt <= '0;
            r_chase    <= LED_W'(1);
            r_phase    <= 1'b1;
        end else begin
            leds <= w_led_next;
            if (w_cmd.next || w_cmd.home) begin
                // Every command restarts the target mode from scratch.
                mode       <= w_mode_next;
                r_step_cnt <= '0;
                if (w_mode_next == MODE_CHASE) begin
                    r_chase <= LED_W'(1);
                end
                if (w_mode_next == MODE_BLINK) begin
                    r_phase <= 1'b1;
                end
            end else if (mode == MODE_CHASE || mode == MODE_BLINK) begin
                if (r_step_cnt == SW'(STEP_CYCLES - 1)) begin
                    r_step_cnt <= '0;
                    if (mode == MODE_CHASE) begin
                        r_chase <= switches[0] ? {r_chase[0], r_chase[LED_W-1:1]}
                                               : {r_chase[LED_W-2:0], r_chase[LED_W-1]};
                    end else begin
                        r_phase <= ~r_phase;
                    end
                end else begin
                    r_step_cnt <= r_step_cnt + SW'(1);
                end
            end else begin
                r_step_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire
